reduce_accum: RTL and testbench

Parametrised, sequential successor to the fixed 8-input x 4-bit bitwise AND reducer. Instead of taking COUNT operands in parallel, it takes one WIDTH-bit operand per beat over a valid/ready stream. It folds up to COUNT beats bitwise with a runtime-selectable operator (AND/OR/XOR/XNOR), then presents one result word on a valid/ready output. Frames may end early via in_last. It sits between operand producers and consumers where the parallel reducer's wide fan-in is too costly.

---
 rtl/reduce_accum_pkg.sv | 20 ++
 rtl/reduce_op.sv | 33 +++
 rtl/reduce_accum.sv | 150 +++++++++++++++
 tb/tb_reduce_accum.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/reduce_accum_pkg.sv
// -----------------------------------------------------------------------------
// reduce_accum_pkg
// Shared definitions for the sequential bitwise reducer:
//   - 2-bit operator encodings selecting the fold function
//   - FSM state encoding for the frame controller
// -----------------------------------------------------------------------------
package reduce_accum_pkg;

    localparam logic [1:0] OP_AND  = 2'd0;
    localparam logic [1:0] OP_OR   = 2'd1;
    localparam logic [1:0] OP_XOR  = 2'd2;
    localparam logic [1:0] OP_XNOR = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/reduce_op.sv
// -----------------------------------------------------------------------------
// reduce_op
// One combinational fold step: y = a OP b, bitwise, no carries.
// Ports:
//   op  [1:0]      operator select (AND/OR/XOR/XNOR)
//   a   [WIDTH-1:0] running accumulator
//   b   [WIDTH-1:0] incoming operand
//   y   [WIDTH-1:0] folded result
// -----------------------------------------------------------------------------
module reduce_op
    import reduce_accum_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Operator decode; XNOR is a pairwise step, not a complemented XOR reduction
    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: y = a & b;
        endcase
    end

endmodule

// File: rtl/reduce_accum.sv
// -----------------------------------------------------------------------------
// reduce_accum
// Sequential bitwise reducer: folds up to COUNT WIDTH-bit beats received on a
// valid/ready stream using the operator sampled on the first beat, then
// presents one result word on a valid/ready output.
// Ports:
//   CLK, ASYNCRESETN          clock (rising edge), async active-low reset
//   op [1:0]                  operator, sampled on the first beat of a frame
//   in_valid/in_ready         input beat handshake
//   in_data [WIDTH-1:0]       operand
//   in_last                   closes the frame early
//   out_valid/out_ready       result handshake
//   out_data [WIDTH-1:0]      reduced result
//   out_count [CW-1:0]        beats folded into out_data (1..COUNT)
// -----------------------------------------------------------------------------
module reduce_accum
    import reduce_accum_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int COUNT = 8,
    localparam int CW    = $clog2(COUNT + 1)
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic [1:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_count
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_nxt_s;
    logic [1:0]       op_q_r;
    logic [1:0]       op_nxt_s;
    logic [WIDTH-1:0] fold_s;
    logic             beat_s;
    logic             close_s;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [CW-1:0]    out_count_r;

    // Input acceptance depends on state alone, so no combinational path from out_ready
    assign in_ready  = (state_r != HOLD);
    assign beat_s    = in_valid & in_ready;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_count = out_count_r;

    reduce_op #(.WIDTH(WIDTH)) u_reduce_op (
        .op (op_q_r),
        .a  (acc_r),
        .b  (in_data),
        .y  (fold_s)
    );

    // Next-state, accumulator and counter update; close_s marks the frame's final beat
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        cnt_nxt_s   = cnt_r;
        op_nxt_s    = op_q_r;
        close_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (beat_s) begin
                    // First beat seeds the accumulator, so no identity value is needed
                    acc_nxt_s = in_data;
                    op_nxt_s  = op;
                    cnt_nxt_s = CW'(1);
                    if (in_last || (COUNT == 1)) begin
                        state_nxt_s = HOLD;
                        close_s     = 1'b1;
                    end else begin
                        state_nxt_s = ACCUM;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCUM: begin
                if (beat_s) begin
                    acc_nxt_s = fold_s;
                    cnt_nxt_s = cnt_r + CW'(1);
                    if (in_last || (cnt_r == CW'(COUNT - 1))) begin
                        state_nxt_s = HOLD;
                        close_s     = 1'b1;
                    end else begin
                        state_nxt_s = ACCUM;
                    end
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            HOLD: begin
                if (out_valid_r && out_ready) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Frame state registers
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_r <= IDLE;
            acc_r   <= '0;
            cnt_r   <= '0;
            op_q_r  <= OP_AND;
        end else begin
            state_r <= state_nxt_s;
            acc_r   <= acc_nxt_s;
            cnt_r   <= cnt_nxt_s;
            op_q_r  <= op_nxt_s;
        end
    end

    // Result registers: loaded with the closing fold, data/count persist after handshake
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_count_r <= '0;
        end else if (close_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= acc_nxt_s;
            out_count_r <= cnt_nxt_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

endmodule

// File: tb/tb_reduce_accum.sv
// -----------------------------------------------------------------------------
// tb_reduce_accum
// Directed bench: a table of frames with hand-computed results plus hand-written
// sequences for back-pressure, asynchronous reset and a COUNT=1/WIDTH=1 build.
// -----------------------------------------------------------------------------
module tb_reduce_accum;

    logic       CLK;
    logic       ASYNCRESETN;
    logic [1:0] op;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [3:0] out_count;

    logic       in_valid1;
    logic       in_ready1;
    logic [0:0] in_data1;
    logic       out_valid1;
    logic [0:0] out_data1;
    logic [0:0] out_count1;

    int n_vec = 0;
    int n_err = 0;

    reduce_accum #(.WIDTH(4), .COUNT(8)) u_dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .op          (op),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_count   (out_count)
    );

    reduce_accum #(.WIDTH(1), .COUNT(1)) u_dut1 (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .op          (2'd0),
        .in_valid    (in_valid1),
        .in_ready    (in_ready1),
        .in_data     (in_data1),
        .in_last     (1'b0),
        .out_valid   (out_valid1),
        .out_ready   (1'b1),
        .out_data    (out_data1),
        .out_count   (out_count1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  op0;    // operator on beat 0
        logic [1:0]  opr;    // operator driven on later beats (must be ignored)
        int          n;      // beats in frame
        logic [31:0] d;      // beat i in d[4*i +: 4]
        logic        last;   // in_last on the final beat
        logic [3:0]  exp_d;
        logic [3:0]  exp_c;
        int          hold;   // cycles of out_ready=0 after the result appears
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        out_ready = (v.hold == 0);
        for (int i = 0; i < v.n; i++) begin
            @(negedge CLK);
            chk({tag, "_in_ready_beat"}, 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = v.d[4*i +: 4];
            op       = (i == 0) ? v.op0 : v.opr;
            in_last  = (i == v.n - 1) ? v.last : 1'b0;
        end
        @(negedge CLK);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_out_data"},  32'(out_data),  32'(v.exp_d));
        chk({tag, "_out_count"}, 32'(out_count), 32'(v.exp_c));
        chk({tag, "_in_ready_hold"}, 32'(in_ready), 32'd0);
        // While stalled, offer a junk closing beat that must not be absorbed
        in_valid = (v.hold != 0);
        in_data  = 4'h0;
        op       = 2'd0;
        in_last  = (v.hold != 0);
        for (int k = 0; k < v.hold; k++) begin
            @(negedge CLK);
            chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_stall_data"},  32'(out_data),  32'(v.exp_d));
            chk({tag, "_stall_ready"}, 32'(in_ready),  32'd0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge CLK);
        chk({tag, "_after_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_after_ready"}, 32'(in_ready),  32'd1);
        chk({tag, "_after_data"},  32'(out_data),  32'(v.exp_d));
    endtask

    initial begin
        logic [5:0] pat;
        vec_t       v;
        tbl[0] = '{2'd0, 2'd0, 8, 32'hFFFF_EFFF, 1'b0, 4'hE, 4'd8, 0}; // AND, closes on COUNT
        tbl[1] = '{2'd1, 2'd1, 3, 32'h0000_0821, 1'b1, 4'hB, 4'd3, 0}; // OR, early last
        tbl[2] = '{2'd0, 2'd0, 1, 32'h0000_0005, 1'b1, 4'h5, 4'd1, 0}; // single beat
        tbl[3] = '{2'd3, 2'd0, 3, 32'h0000_06AC, 1'b1, 4'h0, 4'd3, 0}; // op switched mid-frame
        tbl[4] = '{2'd2, 2'd2, 4, 32'h0000_0F53, 1'b1, 4'h9, 4'd4, 5}; // XOR 3^5^F^0, stalled
        tbl[5] = '{2'd1, 2'd1, 8, 32'h0000_8421, 1'b1, 4'hF, 4'd8, 0}; // redundant last on 8th
        tbl[6] = '{2'd3, 2'd3, 3, 32'h0000_0000, 1'b1, 4'h0, 4'd3, 0}; // XNOR pairwise of zeros
        tbl[7] = '{2'd3, 2'd3, 2, 32'h0000_0035, 1'b1, 4'h9, 4'd2, 0}; // ~(5^3)

        ASYNCRESETN = 1'b0;
        op = 2'd0; in_valid = 1'b0; in_data = 4'h0; in_last = 1'b0; out_ready = 1'b1;
        in_valid1 = 1'b0; in_data1 = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        ASYNCRESETN = 1'b1;
        @(negedge CLK);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 8; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

        // Reset mid-frame after 3 beats: previous result (9,4... then last frame) is cleared
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            in_valid = 1'b1; in_data = 4'hF; op = 2'd0; in_last = 1'b0;
        end
        @(negedge CLK);
        in_valid = 1'b0;
        #2 ASYNCRESETN = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data",  32'(out_data),  32'd0);
        chk("midrst_out_count", 32'(out_count), 32'd0);
        #1 ASYNCRESETN = 1'b1;
        v = '{2'd0, 2'd0, 8, 32'hFFFF_FFFF, 1'b0, 4'hF, 4'd8, 0};
        run_frame(v, "postrst");

        // Reset while a result is pending: out_valid drops without a clock
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            in_valid = 1'b1; in_data = 4'h7; op = 2'd0; in_last = (i == 1);
        end
        @(negedge CLK);
        in_valid = 1'b0; in_last = 1'b0;
        chk("holdrst_pre_valid", 32'(out_valid), 32'd1);
        #2 ASYNCRESETN = 1'b0;
        #1;
        chk("holdrst_out_valid", 32'(out_valid), 32'd0);
        chk("holdrst_out_data",  32'(out_data),  32'd0);
        chk("holdrst_in_ready",  32'(in_ready),  32'd1);
        #1 ASYNCRESETN = 1'b1;
        out_ready = 1'b1;
        run_frame(tbl[1], "postholdrst");

        // COUNT=1, WIDTH=1: in_valid held high gives one result every two cycles
        pat = 6'b101101;
        @(negedge CLK);
        in_valid1 = 1'b1;
        in_data1  = pat[0];
        for (int j = 0; j < 6; j++) begin
            @(negedge CLK);
            chk($sformatf("c1_valid_%0d", j), 32'(out_valid1), 32'd1);
            chk($sformatf("c1_data_%0d", j),  32'(out_data1),  32'(pat[j]));
            chk($sformatf("c1_count_%0d", j), 32'(out_count1), 32'd1);
            chk($sformatf("c1_ready_%0d", j), 32'(in_ready1),  32'd0);
            in_data1 = pat[(j + 1) % 6];
            @(negedge CLK);
            chk($sformatf("c1_gap_valid_%0d", j), 32'(out_valid1), 32'd0);
            chk($sformatf("c1_gap_ready_%0d", j), 32'(in_ready1),  32'd1);
        end
        in_valid1 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
